// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the operand-2 barrel shifter: datapath width and
// the shift-type encoding carried in in_Shift_type.
package barrel_shifter_pkg;

    localparam int WordWidth = 32;

    typedef enum logic [1:0] {
        LogicalLeftShift     = 2'b00,
        LogicalRightShift    = 2'b01,
        ArithmeticRightShift = 2'b10,
        RotateRightShift     = 2'b11
    } shift_type_e;

endpackage

// File: rtl/barrel_shifter_rotate_right32.sv
// 32-bit combinational rotate-right, five log stages (1, 2, 4, 8, 16).
// Shared by the register-path shifts and the immediate rotation.
module rotate_right32 (
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    output logic [31:0] result
);

    logic [5:0][31:0] stage;

    assign stage[0] = data;

    // Stage k rotates by 2**k when amount[k] is set.
    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stage[k+1] = amount[k] ? {stage[k][S-1:0], stage[k][31:S]} : stage[k];
    end

    assign result = stage[5];

endmodule

// File: rtl/barrel_shifter.sv
// Operand-2 shifter: register path (LSL/LSR/ASR/ROR/RRX with the #0 special
// encodings) or 8-bit immediate rotated by 2*rotate. One rotator does all the
// bit movement; LSL uses a rotate by -n and the shifts mask the wrapped bits.
// Result and carry are registered once, giving single-cycle latency.
module barrel_shifter #(
    parameter int WordWidth = barrel_shifter_pkg::WordWidth
) (
    input  logic        in_Clk,
    input  logic        in_Rst_n,
    input  logic [31:0] in_Reg_val,
    input  logic [31:0] in_Imm_val,
    input  logic [4:0]  in_Shift_val,
    input  logic [3:0]  in_Rotate,
    input  logic [1:0]  in_Shift_type,
    input  logic        in_C_flag,
    input  logic        in_Imm_en,
    output logic [31:0] out_Op2,
    output logic        out_Carry
);

    import barrel_shifter_pkg::*;

    logic [31:0]   rot_data;
    logic [4:0]    rot_amt;
    logic [31:0]   rot_res;
    logic [31:0]   lsl_mask;
    logic [31:0]   lsr_mask;
    logic [31:0]   sign_fill;
    logic [4:0]    neg_n;
    logic [4:0]    n_minus1;
    logic [31:0]   next_op2;
    logic          next_carry;
    shift_type_e   shift_type;

    // Select rotator operand and amount; LSL n is a rotate right by 32-n.
    always_comb begin
        shift_type = shift_type_e'(in_Shift_type);
        neg_n      = 5'd0 - in_Shift_val;
        n_minus1   = in_Shift_val - 5'd1;
        if (in_Imm_en) begin
            rot_data = {24'd0, in_Imm_val[7:0]};
            rot_amt  = {in_Rotate, 1'b0};
        end else begin
            rot_data = in_Reg_val;
            rot_amt  = (shift_type == LogicalLeftShift) ? neg_n : in_Shift_val;
        end
    end

    rotate_right32 u_rot (
        .data   (rot_data),
        .amount (rot_amt),
        .result (rot_res)
    );

    assign lsl_mask  = {WordWidth{1'b1}} << in_Shift_val;
    assign lsr_mask  = {WordWidth{1'b1}} >> in_Shift_val;
    assign sign_fill = {WordWidth{in_Reg_val[31]}};

    // Mask wrapped bits, handle #0 encodings and pick the carry-out.
    always_comb begin
        next_op2   = rot_res;
        next_carry = in_C_flag;
        if (in_Imm_en) begin
            next_op2   = rot_res;
            next_carry = (in_Rotate == 4'd0) ? in_C_flag : rot_res[31];
        end else begin
            unique case (shift_type)
                LogicalLeftShift: begin
                    if (in_Shift_val == 5'd0) begin
                        next_op2   = in_Reg_val;
                        next_carry = in_C_flag;
                    end else begin
                        next_op2   = rot_res & lsl_mask;
                        next_carry = in_Reg_val[neg_n];
                    end
                end
                LogicalRightShift: begin
                    if (in_Shift_val == 5'd0) begin
                        next_op2   = '0;
                        next_carry = in_Reg_val[31];
                    end else begin
                        next_op2   = rot_res & lsr_mask;
                        next_carry = in_Reg_val[n_minus1];
                    end
                end
                ArithmeticRightShift: begin
                    if (in_Shift_val == 5'd0) begin
                        next_op2   = sign_fill;
                        next_carry = in_Reg_val[31];
                    end else begin
                        next_op2   = (rot_res & lsr_mask) | (sign_fill & ~lsr_mask);
                        next_carry = in_Reg_val[n_minus1];
                    end
                end
                RotateRightShift: begin
                    if (in_Shift_val == 5'd0) begin
                        next_op2   = {in_C_flag, in_Reg_val[31:1]};
                        next_carry = in_Reg_val[0];
                    end else begin
                        next_op2   = rot_res;
                        next_carry = rot_res[31];
                    end
                end
                default: begin
                    next_op2   = rot_res;
                    next_carry = in_C_flag;
                end
            endcase
        end
    end

    // Output register, cleared asynchronously.
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            out_Op2   <= '0;
            out_Carry <= 1'b0;
        end else begin
            out_Op2   <= next_op2;
            out_Carry <= next_carry;
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter: directed ARM operand-2 cases, asynchronous reset
// behaviour, then random vectors against an arithmetic reference model.
module tb_barrel_shifter;

    logic        in_Clk = 1'b0;
    logic        in_Rst_n;
    logic [31:0] in_Reg_val;
    logic [31:0] in_Imm_val;
    logic [4:0]  in_Shift_val;
    logic [3:0]  in_Rotate;
    logic [1:0]  in_Shift_type;
    logic        in_C_flag;
    logic        in_Imm_en;
    logic [31:0] out_Op2;
    logic        out_Carry;

    int n_vec = 0;
    int n_bad = 0;

    barrel_shifter dut (
        .in_Clk        (in_Clk),
        .in_Rst_n      (in_Rst_n),
        .in_Reg_val    (in_Reg_val),
        .in_Imm_val    (in_Imm_val),
        .in_Shift_val  (in_Shift_val),
        .in_Rotate     (in_Rotate),
        .in_Shift_type (in_Shift_type),
        .in_C_flag     (in_C_flag),
        .in_Imm_en     (in_Imm_en),
        .out_Op2       (out_Op2),
        .out_Carry     (out_Carry)
    );

    always #5 in_Clk = ~in_Clk;

    // Reference: shifts done on a 64-bit window so shifted-out bits are visible.
    function automatic void model(input logic [31:0] rm, input logic [31:0] imm,
                                  input logic [4:0] n, input logic [3:0] rot,
                                  input logic [1:0] typ, input logic c, input logic ie,
                                  output logic [31:0] op2, output logic cy);
        logic [63:0] w;
        logic signed [63:0] ws;
        int amt;
        if (ie) begin
            w   = {24'd0, imm[7:0], 24'd0, imm[7:0]} >> (2 * int'(rot));
            op2 = w[31:0];
            cy  = (rot == 0) ? c : op2[31];
        end else begin
            amt = (n == 0) ? 32 : int'(n);
            case (typ)
                2'b00: begin
                    w   = {32'd0, rm} << n;
                    op2 = w[31:0];
                    cy  = (n == 0) ? c : w[32];
                end
                2'b01: begin
                    w   = {rm, 32'd0} >> amt;
                    op2 = w[63:32];
                    cy  = w[31];
                end
                2'b10: begin
                    ws  = $signed({rm, 32'd0}) >>> amt;
                    op2 = ws[63:32];
                    cy  = ws[31];
                end
                default: begin
                    if (n == 0) begin
                        op2 = {c, rm[31:1]};
                        cy  = rm[0];
                    end else begin
                        w   = {rm, rm} >> n;
                        op2 = w[31:0];
                        cy  = op2[31];
                    end
                end
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] e_op2, input logic e_c);
        n_vec++;
        assert ({out_Op2, out_Carry} === {e_op2, e_c}) else begin
            n_bad++;
            $error("FAIL %s: got op2=%h carry=%b, want op2=%h carry=%b",
                   tag, out_Op2, out_Carry, e_op2, e_c);
        end
    endtask

    task automatic drive(input logic [31:0] rm, input logic [31:0] imm, input logic [4:0] n,
                         input logic [3:0] rot, input logic [1:0] typ, input logic c,
                         input logic ie);
        in_Reg_val = rm; in_Imm_val = imm; in_Shift_val = n; in_Rotate = rot;
        in_Shift_type = typ; in_C_flag = c; in_Imm_en = ie;
    endtask

    // Apply one register-path operation and compare after one edge.
    task automatic reg_op(input string tag, input logic [31:0] rm, input logic [4:0] n,
                          input logic [1:0] typ, input logic c,
                          input logic [31:0] e_op2, input logic e_c);
        drive(rm, 32'hDEAD_BE00, n, 4'hA, typ, c, 1'b0);
        @(posedge in_Clk); #1;
        check(tag, e_op2, e_c);
    endtask

    task automatic imm_op(input string tag, input logic [31:0] imm, input logic [3:0] rot,
                          input logic c, input logic [31:0] e_op2, input logic e_c);
        drive(32'h1234_5678, imm, 5'd7, rot, 2'b01, c, 1'b1);
        @(posedge in_Clk); #1;
        check(tag, e_op2, e_c);
    endtask

    initial begin
        logic [31:0] rm, imm, e_op2;
        logic [4:0]  n;
        logic [3:0]  rot;
        logic [1:0]  typ;
        logic        c, ie, e_c;

        drive(32'd0, 32'd0, 5'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        in_Rst_n = 1'b1;
        #3 in_Rst_n = 1'b0;
        #1 check("reset_state", 32'd0, 1'b0);
        @(posedge in_Clk); #1;
        check("reset_hold", 32'd0, 1'b0);
        @(negedge in_Clk);
        in_Rst_n = 1'b1;

        reg_op("lsl1",      32'd2, 5'd1, 2'b00, 1'b0, 32'd4, 1'b0);
        reg_op("lsl0",      32'd2, 5'd0, 2'b00, 1'b1, 32'd2, 1'b1);
        reg_op("lsl31",     32'h0000_0003, 5'd31, 2'b00, 1'b0, 32'h8000_0000, 1'b1);
        reg_op("lsr1",      32'd2, 5'd1, 2'b01, 1'b1, 32'd1, 1'b0);
        reg_op("lsr0_32",   32'h8000_0002, 5'd0, 2'b01, 1'b0, 32'd0, 1'b1);
        reg_op("asr10",     32'd13244, 5'd10, 2'b10, 1'b1, 32'd12, 1'b1);
        reg_op("asr0_32",   32'd4290000000, 5'd0, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1);
        reg_op("asr31_neg", 32'h8000_0000, 5'd31, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0);
        reg_op("ror4",      32'd200, 5'd4, 2'b11, 1'b0, 32'h8000_000C, 1'b1);
        reg_op("rrx_c1",    32'd200, 5'd0, 2'b11, 1'b1, 32'h8000_0064, 1'b0);
        reg_op("rrx_c0",    32'd200, 5'd0, 2'b11, 1'b0, 32'd100, 1'b0);
        imm_op("imm_rot4",  32'hFFFF_FFFF, 4'd4, 1'b0, 32'hFF00_0000, 1'b1);
        imm_op("imm_rot0",  32'h0000_00FF, 4'd0, 1'b1, 32'h0000_00FF, 1'b1);
        imm_op("imm_rot1",  32'h0000_0081, 4'd1, 1'b0, 32'h4000_0020, 1'b0);

        // Asynchronous reset between edges with a nonzero result pending.
        reg_op("pre_reset", 32'h0000_00F0, 5'd4, 2'b00, 1'b1, 32'h0000_0F00, 1'b0);
        #2 in_Rst_n = 1'b0;
        #1 check("async_reset", 32'd0, 1'b0);
        drive(32'hFFFF_FFFF, 32'd0, 5'd0, 4'd0, 2'b10, 1'b1, 1'b0);
        @(posedge in_Clk); #1;
        check("reset_hold2", 32'd0, 1'b0);
        @(negedge in_Clk);
        in_Rst_n = 1'b1;
        @(posedge in_Clk); #1;
        check("post_release", 32'hFFFF_FFFF, 1'b1);

        // Random traffic, back-to-back, one result per cycle.
        for (int i = 0; i < 400; i++) begin
            rm  = $urandom;
            imm = $urandom;
            n   = 5'($urandom_range(0, 31));
            if ((i % 8) == 0) n = 5'd0;
            rot = 4'($urandom_range(0, 15));
            typ = 2'($urandom_range(0, 3));
            c   = 1'($urandom_range(0, 1));
            ie  = ($urandom_range(0, 3) == 0);
            drive(rm, imm, n, rot, typ, c, ie);
            model(rm, imm, n, rot, typ, c, ie, e_op2, e_c);
            @(posedge in_Clk); #1;
            check("random", e_op2, e_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
